// File: rtl/pipe_ctrl_regs_pkg.sv
// Shared types for the control-side pipeline: ARM condition codes, NZCV flags,
// the per-stage control bundle and the condition evaluator.
package pipe_ctrl_regs_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
  } cond_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       pc_src;
    logic       alu_src;
    logic [1:0] alu_control;
    logic [1:0] flag_write;
    cond_t      cond;
  } ctrl_t;

  // A bubble is an unconditional no-op so it can never be squashed into doing work.
  localparam ctrl_t CTRL_BUBBLE = '{reg_write: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                                    branch: 1'b0, pc_src: 1'b0, alu_src: 1'b0,
                                    alu_control: 2'b00, flag_write: 2'b00, cond: COND_AL};
  localparam ctrl_t CTRL_RESET  = '{reg_write: 1'b0, mem_write: 1'b0, mem_to_reg: 1'b0,
                                    branch: 1'b0, pc_src: 1'b0, alu_src: 1'b0,
                                    alu_control: 2'b00, flag_write: 2'b00, cond: COND_EQ};

  function automatic logic cond_check(input cond_t cond, input flags_t f);
    logic r;
    case (cond)
      COND_EQ: r = f.z;
      COND_NE: r = ~f.z;
      COND_CS: r = f.c;
      COND_CC: r = ~f.c;
      COND_MI: r = f.n;
      COND_PL: r = ~f.n;
      COND_VS: r = f.v;
      COND_VC: r = ~f.v;
      COND_HI: r = f.c & ~f.z;
      COND_LS: r = ~f.c | f.z;
      COND_GE: r = (f.n == f.v);
      COND_LT: r = (f.n != f.v);
      COND_GT: r = ~f.z & (f.n == f.v);
      COND_LE: r = f.z | (f.n != f.v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pipe_ctrl_regs_cond_unit.sv
// E-stage condition unit: decides whether the instruction in E executes and
// which halves of the flags register it is allowed to update.
module pipe_ctrl_regs_cond_unit
  import pipe_ctrl_regs_pkg::*;
(
  input  cond_t      cond,
  input  flags_t     flags,
  input  logic [1:0] flag_write,
  output logic       cond_ex,
  output logic [1:0] flag_en
);

  // Condition pass and gated flag-write enables
  always_comb begin
    cond_ex = cond_check(cond, flags);
    flag_en = flag_write & {2{cond_ex}};
  end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// Control-side pipeline registers F/D -> D/E -> E/M -> M/WB with the NZCV
// flags register and E-stage condition gating.
module pipe_ctrl_regs
  import pipe_ctrl_regs_pkg::*;
#(
  parameter int                 INSTR_W     = 32,
  parameter logic [INSTR_W-1:0] FLUSH_INSTR = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [INSTR_W-1:0] InstrF,
  input  logic               StallD,
  input  logic               FlushD,
  input  logic               FlushE,
  output logic [INSTR_W-1:0] InstrD,
  output logic               ValidD,
  input  logic               RegWriteD,
  input  logic               MemWriteD,
  input  logic               MemtoRegD,
  input  logic               BranchD,
  input  logic               PCSrcD,
  input  logic               ALUSrcD,
  input  logic [1:0]         ALUControlD,
  input  logic [1:0]         FlagWriteD,
  input  logic [3:0]         CondD,
  input  logic [3:0]         ra1D,
  input  logic [3:0]         ra2D,
  input  logic [3:0]         wa3D,
  input  logic [3:0]         ALUFlagsE,
  output logic [3:0]         ra1E,
  output logic [3:0]         ra2E,
  output logic [3:0]         wa3E,
  output logic [1:0]         ALUControlE,
  output logic               ALUSrcE,
  output logic               MemtoRegE,
  output logic               PCSrcE,
  output logic               BranchTakenE,
  output logic               RegWriteM,
  output logic               MemWriteM,
  output logic               MemtoRegM,
  output logic               PCSrcM,
  output logic [3:0]         wa3M,
  output logic               RegWriteWB,
  output logic               MemtoRegWB,
  output logic               PCSrcWB,
  output logic [3:0]         wa3WB,
  output logic [3:0]         FlagsQ
);

  ctrl_t      ctrl_d_s;
  ctrl_t      ctrl_e_r;
  logic [3:0] ra1_d_s, ra2_d_s, wa3_d_s;
  flags_t     flags_r;
  logic       cond_ex_s;
  logic [1:0] flag_en_s;

  // F/D register: flush beats stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      InstrD <= FLUSH_INSTR;
      ValidD <= 1'b0;
    end else if (FlushD) begin
      InstrD <= FLUSH_INSTR;
      ValidD <= 1'b0;
    end else if (!StallD) begin
      InstrD <= InstrF;
      ValidD <= 1'b1;
    end
  end

  // D-stage bundle, replaced by a bubble on FlushE or an empty D slot
  always_comb begin
    ctrl_d_s = CTRL_BUBBLE;
    ra1_d_s  = 4'h0;
    ra2_d_s  = 4'h0;
    wa3_d_s  = 4'h0;
    if (FlushE || !ValidD) begin
      ctrl_d_s = CTRL_BUBBLE;
    end else begin
      ctrl_d_s = '{reg_write: RegWriteD, mem_write: MemWriteD, mem_to_reg: MemtoRegD,
                   branch: BranchD, pc_src: PCSrcD, alu_src: ALUSrcD,
                   alu_control: ALUControlD, flag_write: FlagWriteD, cond: cond_t'(CondD)};
      ra1_d_s  = ra1D;
      ra2_d_s  = ra2D;
      wa3_d_s  = wa3D;
    end
  end

  // D/E register, never stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_e_r <= CTRL_RESET;
      ra1E     <= 4'h0;
      ra2E     <= 4'h0;
      wa3E     <= 4'h0;
    end else begin
      ctrl_e_r <= ctrl_d_s;
      ra1E     <= ra1_d_s;
      ra2E     <= ra2_d_s;
      wa3E     <= wa3_d_s;
    end
  end

  pipe_ctrl_regs_cond_unit u_cond (
    .cond       (ctrl_e_r.cond),
    .flags      (flags_r),
    .flag_write (ctrl_e_r.flag_write),
    .cond_ex    (cond_ex_s),
    .flag_en    (flag_en_s)
  );

  assign ALUControlE  = ctrl_e_r.alu_control;
  assign ALUSrcE      = ctrl_e_r.alu_src;
  assign MemtoRegE    = ctrl_e_r.mem_to_reg;
  assign PCSrcE       = ctrl_e_r.pc_src & cond_ex_s;
  assign BranchTakenE = ctrl_e_r.branch & cond_ex_s;
  assign FlagsQ       = flags_r;

  // NZCV register; FlushE does not block the update from what is already in E
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_r <= flags_t'(4'b0000);
    end else begin
      if (flag_en_s[1]) begin
        flags_r.n <= ALUFlagsE[3];
        flags_r.z <= ALUFlagsE[2];
      end
      if (flag_en_s[0]) begin
        flags_r.c <= ALUFlagsE[1];
        flags_r.v <= ALUFlagsE[0];
      end
    end
  end

  // E/M and M/WB registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      MemtoRegM  <= 1'b0;
      PCSrcM     <= 1'b0;
      wa3M       <= 4'h0;
      RegWriteWB <= 1'b0;
      MemtoRegWB <= 1'b0;
      PCSrcWB    <= 1'b0;
      wa3WB      <= 4'h0;
    end else begin
      RegWriteM  <= ctrl_e_r.reg_write & cond_ex_s;
      MemWriteM  <= ctrl_e_r.mem_write & cond_ex_s;
      MemtoRegM  <= ctrl_e_r.mem_to_reg;
      PCSrcM     <= ctrl_e_r.pc_src & cond_ex_s;
      wa3M       <= wa3E;
      RegWriteWB <= RegWriteM;
      MemtoRegWB <= MemtoRegM;
      PCSrcWB    <= PCSrcM;
      wa3WB      <= wa3M;
    end
  end

endmodule
